// File: rtl/hdr_pkg.sv
// Shared header definitions: pin count, measurement FSM encoding and a range helper.
package hdr_pkg;

  localparam int unsigned NUM_PINS = 37;
  localparam int unsigned SEL_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_EVAL   = 2'd3
  } hdr_state_e;

  function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                     input int unsigned hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/header_pin_counter.sv
// One header pin: 2-FF synchroniser, history flop, rising-edge detect and saturating counter.
module header_pin_counter
  import hdr_pkg::*;
#(
  parameter int unsigned EDGE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin_in,
  input  logic              clear,
  input  logic              enable,
  output logic [EDGE_W-1:0] count
);

  logic              sync1_q, sync2_q, hist_q;
  logic [EDGE_W-1:0] count_q, count_d;
  logic              rise;

  always_comb begin
    rise    = sync2_q & ~hist_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && rise && (count_q != {EDGE_W{1'b1}})) begin
      count_d = count_q + EDGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/header_edge_checker.sv
// Counts rising edges per header pin over a gate window and flags pins outside the
// expected edge count; results hold until the next accepted start.
module header_edge_checker
  import hdr_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned GATE_CYC   = 1000000,
  parameter int unsigned EXP_EDGES  = 10,
  parameter int unsigned TOL        = 1,
  parameter int unsigned EDGE_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] bus_in,
  input  logic                start,
  input  logic [SEL_W-1:0]    sel_pin,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [NUM_PINS-1:0] pin_ok,
  output logic [EDGE_W-1:0]   sel_count
);

  localparam int unsigned LO_EDGES    = (EXP_EDGES > TOL) ? (EXP_EDGES - TOL) : 0;
  localparam int unsigned HI_EDGES    = EXP_EDGES + TOL;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] GATE_LAST   = 32'(GATE_CYC - 1);

  if (SETTLE_CYC == 0 || GATE_CYC == 0) begin : g_bad_params
    $error("header_edge_checker: SETTLE_CYC and GATE_CYC must be >= 1");
  end

  hdr_state_e          state_q, state_d;
  logic [31:0]         cyc_q, cyc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [NUM_PINS-1:0] pin_ok_q, pin_ok_d;
  logic [EDGE_W-1:0]   sel_count_q, sel_count_d;
  logic                clear_c, enable_c;
  logic [NUM_PINS-1:0] ok_c;
  logic [EDGE_W-1:0]   cnt [NUM_PINS];

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    header_pin_counter #(.EDGE_W(EDGE_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .pin_in (bus_in[i]),
      .clear  (clear_c),
      .enable (enable_c),
      .count  (cnt[i])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_PINS; i++) begin
      ok_c[i] = in_window(32'(cnt[i]), LO_EDGES, HI_EDGES);
    end
  end

  // Measurement sequencing; a start coinciding with done is deliberately dropped.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    pin_ok_d = pin_ok_q;
    clear_c  = 1'b0;
    enable_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          state_d  = ST_SETTLE;
          cyc_d    = '0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          pin_ok_d = '0;
          clear_c  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          state_d = ST_GATE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_GATE: begin
        enable_c = 1'b1;
        if (cyc_q == GATE_LAST) begin
          state_d = ST_EVAL;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_EVAL: begin
        pin_ok_d = ok_c;
        pass_d   = &ok_c;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    sel_count_d = (32'(sel_pin) < NUM_PINS) ? cnt[sel_pin] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      pin_ok_q    <= '0;
      sel_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      pin_ok_q    <= pin_ok_d;
      sel_count_q <= sel_count_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign pin_ok    = pin_ok_q;
  assign sel_count = sel_count_q;

endmodule

// File: tb/tb_header_edge_checker.sv
// Directed bench for header_edge_checker with short settle/gate windows.
module tb_header_edge_checker;
  import hdr_pkg::*;

  localparam int unsigned NP = NUM_PINS;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NP-1:0] bus_in = '0;
  logic [5:0]    sel_pin = '0;
  logic          busy, done, pass;
  logic [NP-1:0] pin_ok;
  logic [EW-1:0] sel_count;

  int   per [NP];
  logic lvl [NP];
  int   tick = 0;
  int   done_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  header_edge_checker #(
    .SETTLE_CYC(20), .GATE_CYC(1000), .EXP_EDGES(10), .TOL(1), .EDGE_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .start(start), .sel_pin(sel_pin),
    .busy(busy), .done(done), .pass(pass), .pin_ok(pin_ok), .sel_count(sel_count)
  );

  initial forever #5 clk = ~clk;

  // Pin waveform generator: square wave of period per[i] (phase-shifted), or static lvl[i].
  initial forever begin
    @(negedge clk);
    tick++;
    for (int i = 0; i < NP; i++) begin
      if (per[i] == 0) bus_in[i] = lvl[i];
      else             bus_in[i] = (((tick + i * 7) % per[i]) < (per[i] / 2));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic set_all(input int p);
    for (int i = 0; i < NP; i++) begin
      per[i] = p;
      lvl[i] = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, lat);
    end
  endtask

  task automatic read_count(input int p, output logic [EW-1:0] v);
    @(posedge clk); #1 sel_pin = 6'(p);
    @(posedge clk); #1 v = sel_count;
  endtask

  task automatic check_latency(input string name, input int lat);
    n_cmp++;
    if (lat < 1021 || lat > 1023) begin
      n_bad++;
      $display("FAIL %s: start-to-done %0d cycles, want 1021..1023", name, lat);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, pass} !== 3'b000 || pin_ok !== '0) begin
      n_bad++;
      $display("FAIL reset_held: busy/done/pass=%b pin_ok=%h want 000/0", {busy, done, pass}, pin_ok);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, pass} !== 3'b000 || pin_ok !== '0 || sel_count !== '0) begin
      n_bad++;
      $display("FAIL reset_release: busy/done/pass=%b pin_ok=%h cnt=%0d want 000/0/0",
               {busy, done, pass}, pin_ok, sel_count);
    end
  endtask

  task automatic test_all_square();
    int lat = 0;
    logic [EW-1:0] v;
    set_all(100);
    repeat (5) @(posedge clk);
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    wait_done(lat);
    check_latency("square_latency", lat);
    n_cmp++;
    if (pass !== 1'b1 || pin_ok !== {NP{1'b1}}) begin
      n_bad++;
      $display("FAIL square_result: pass=%b pin_ok=%h want 1/all ones", pass, pin_ok);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_one_cycle: done=%b busy=%b want 0/0", done, busy);
    end
    for (int i = 0; i < NP; i++) begin
      read_count(i, v);
      n_cmp++;
      if (v !== 8'd10) begin
        n_bad++;
        $display("FAIL square_count pin %0d: got %0d want 10", i, v);
      end
    end
  endtask

  task automatic test_sel_range();
    logic [EW-1:0] v;
    read_count(40, v);
    n_cmp++;
    if (v !== 8'd0) begin
      n_bad++;
      $display("FAIL sel_out_of_range: got %0d want 0", v);
    end
  endtask

  task automatic test_stuck();
    int lat = 0;
    logic [EW-1:0] v;
    logic [NP-1:0] exp_ok = {NP{1'b1}};
    set_all(100);
    per[5] = 0; lvl[5] = 1'b0;
    per[17] = 0; lvl[17] = 1'b1;
    exp_ok[5] = 1'b0; exp_ok[17] = 1'b0;
    repeat (5) @(posedge clk);
    pulse_start();
    wait_done(lat);
    n_cmp++;
    if (pass !== 1'b0 || pin_ok !== exp_ok) begin
      n_bad++;
      $display("FAIL stuck_result: pass=%b pin_ok=%h want 0/%h", pass, pin_ok, exp_ok);
    end
    read_count(5, v);
    n_cmp++;
    if (v !== 8'd0) begin n_bad++; $display("FAIL stuck_low_count: got %0d want 0", v); end
    read_count(17, v);
    n_cmp++;
    if (v !== 8'd0) begin n_bad++; $display("FAIL stuck_high_count: got %0d want 0", v); end
    read_count(4, v);
    n_cmp++;
    if (v !== 8'd10) begin n_bad++; $display("FAIL stuck_neighbour_count: got %0d want 10", v); end
  endtask

  task automatic test_wrong_rate();
    int lat = 0;
    logic [EW-1:0] v;
    logic [NP-1:0] exp_ok = {NP{1'b1}};
    set_all(100);
    per[0] = 50;
    per[1] = 125;
    exp_ok[0] = 1'b0; exp_ok[1] = 1'b0;
    repeat (5) @(posedge clk);
    pulse_start();
    wait_done(lat);
    n_cmp++;
    if (pass !== 1'b0 || pin_ok !== exp_ok) begin
      n_bad++;
      $display("FAIL rate_result: pass=%b pin_ok=%h want 0/%h", pass, pin_ok, exp_ok);
    end
    read_count(0, v);
    n_cmp++;
    if (v !== 8'd20) begin n_bad++; $display("FAIL fast_count: got %0d want 20", v); end
    read_count(1, v);
    n_cmp++;
    if (v !== 8'd8) begin n_bad++; $display("FAIL slow_count: got %0d want 8", v); end
  endtask

  task automatic test_saturate();
    int lat = 0;
    logic [EW-1:0] v;
    logic [NP-1:0] exp_ok = {NP{1'b1}};
    set_all(100);
    per[2] = 2;
    exp_ok[2] = 1'b0;
    repeat (5) @(posedge clk);
    pulse_start();
    wait_done(lat);
    n_cmp++;
    if (pass !== 1'b0 || pin_ok !== exp_ok) begin
      n_bad++;
      $display("FAIL sat_result: pass=%b pin_ok=%h want 0/%h", pass, pin_ok, exp_ok);
    end
    read_count(2, v);
    n_cmp++;
    if (v !== 8'd255) begin n_bad++; $display("FAIL sat_count: got %0d want 255", v); end
  endtask

  task automatic test_back_to_back();
    int lat = 502;
    int d0;
    set_all(100);
    repeat (5) @(posedge clk);
    d0 = done_cnt;
    pulse_start();
    repeat (500) @(posedge clk);
    pulse_start();
    wait_done(lat);
    check_latency("restart_ignored_latency", lat);
    n_cmp++;
    if (pass !== 1'b1) begin n_bad++; $display("FAIL restart_pass: got %b want 1", pass); end
    repeat (1100) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL single_done: got %0d done pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_gate();
    int lat = 0;
    int d0;
    set_all(100);
    pulse_start();
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, pass} !== 3'b000 || pin_ok !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: busy/done/pass=%b pin_ok=%h want 000/0", {busy, done, pass}, pin_ok);
    end
    rst = 1'b0;
    d0 = done_cnt;
    sel_pin = 6'd3;
    repeat (1100) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt !== d0 || busy !== 1'b0 || sel_count !== '0) begin
      n_bad++;
      $display("FAIL reset_no_done: dones=%0d busy=%b cnt=%0d want 0/0/0",
               done_cnt - d0, busy, sel_count);
    end
    pulse_start();
    wait_done(lat);
    check_latency("post_reset_latency", lat);
    n_cmp++;
    if (pass !== 1'b1 || pin_ok !== {NP{1'b1}}) begin
      n_bad++;
      $display("FAIL post_reset_pass: pass=%b pin_ok=%h want 1/all ones", pass, pin_ok);
    end
  endtask

  task automatic test_settle_edge();
    int lat = 0;
    logic [EW-1:0] v;
    set_all(100);
    per[9] = 0;
    lvl[9] = 1'b0;
    repeat (5) @(posedge clk);
    pulse_start();
    repeat (5) @(posedge clk);
    lvl[9] = 1'b1;
    wait_done(lat);
    n_cmp++;
    if (pin_ok[9] !== 1'b0 || pass !== 1'b0 || pin_ok[8] !== 1'b1) begin
      n_bad++;
      $display("FAIL settle_edge_ok: ok9=%b pass=%b ok8=%b want 0/0/1", pin_ok[9], pass, pin_ok[8]);
    end
    read_count(9, v);
    n_cmp++;
    if (v !== 8'd0) begin n_bad++; $display("FAIL settle_edge_count: got %0d want 0", v); end
  endtask

  initial begin
    set_all(100);
    test_reset();
    test_all_square();
    test_sel_range();
    test_stuck();
    test_wrong_rate();
    test_saturate();
    test_back_to_back();
    test_reset_mid_gate();
    test_settle_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
